// File: rtl/conf_pkg.sv
// Shared types and helpers for the config-driven DMA reader.
package conf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         CMD_START_BIT  = 0;

    // Beats in the next burst: min(max_burst, beats_left, beats to the next 4KB page).
    function automatic logic [4:0] burst_beats(
        input logic [4:0]  max_burst,
        input logic [31:0] beats_left,
        input logic [11:0] addr_lo,
        input int unsigned beat_lsb
    );
        logic [12:0] bytes_to_page;
        logic [31:0] room;
        logic [31:0] n;
        bytes_to_page = 13'h1000 - {1'b0, addr_lo};
        room          = 32'(bytes_to_page >> beat_lsb);
        n             = {27'd0, max_burst};
        if (beats_left < n) n = beats_left;
        if (room < n)       n = room;
        return n[4:0];
    endfunction

endpackage

// File: rtl/conf_dma_reader.sv
// Takes one {CMD,SRC,LEN} command, reads LEN bytes over AXI3 INCR bursts, streams beats out.
// Zero-latency R->OUT pass-through; RREADY follows OUT_READY; CONFIG_READY is low while busy.
module conf_dma_reader
    import conf_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16,
    parameter int ERR_EN    = 1
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              CONFIG_VALID,
    output logic              CONFIG_READY,
    input  logic [31:0]       CONFIG_CMD,
    input  logic [31:0]       CONFIG_SRC,
    input  logic [31:0]       CONFIG_LEN,
    output logic [31:0]       M_AXI_ARADDR,
    output logic [3:0]        M_AXI_ARLEN,
    output logic [2:0]        M_AXI_ARSIZE,
    output logic [1:0]        M_AXI_ARBURST,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RLAST,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              ERR
);

    localparam int BEAT_LSB = $clog2(DATA_W / 8);
    localparam int BL_W     = 32 - BEAT_LSB;

    state_t            state, state_nx;
    logic [31:0]       addr;
    logic [BL_W-1:0]   beats_left;
    logic [4:0]        burst_left;
    logic              err;
    logic [4:0]        n_cur;
    logic              cfg_fire, cfg_go, ar_fire, beat_fire, last_beat, beat_err;
    logic              unused_cfg_bits;

    assign unused_cfg_bits = ^{CONFIG_CMD[31:1], CONFIG_SRC[BEAT_LSB-1:0], CONFIG_LEN[BEAT_LSB-1:0]};

    // addr/beats_left only move on the AR handshake, so ARADDR/ARLEN hold while ARVALID waits.
    assign n_cur     = burst_beats(5'(MAX_BURST), 32'(beats_left), addr[11:0], BEAT_LSB);
    assign cfg_fire  = CONFIG_VALID && (state == ST_IDLE);
    assign cfg_go    = cfg_fire && CONFIG_CMD[CMD_START_BIT] && (CONFIG_LEN[31:BEAT_LSB] != '0);
    assign ar_fire   = (state == ST_ADDR) && M_AXI_ARREADY;
    assign beat_fire = (state == ST_DATA) && M_AXI_RVALID && OUT_READY;
    assign last_beat = (burst_left == 5'd1);
    assign beat_err  = (M_AXI_RRESP != AXI_RESP_OKAY) || (M_AXI_RLAST != last_beat);

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        CONFIG_READY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        OUT_VALID     = 1'b0;
        M_AXI_ARADDR  = addr;
        M_AXI_ARLEN   = 4'(n_cur - 5'd1);
        M_AXI_ARSIZE  = 3'(BEAT_LSB);
        M_AXI_ARBURST = AXI_BURST_INCR;
        OUT_DATA      = M_AXI_RDATA;
        ERR           = err;
        case (state)
            ST_IDLE: begin
                CONFIG_READY = 1'b1;
                if (cfg_go) state_nx = ST_ADDR;
            end
            ST_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (ar_fire) state_nx = ST_DATA;
            end
            ST_DATA: begin
                M_AXI_RREADY = OUT_READY;
                OUT_VALID    = M_AXI_RVALID;
                // Completion is decided by the beat count; RLAST only feeds the error check.
                if (beat_fire && last_beat)
                    state_nx = (beats_left != '0) ? ST_ADDR : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            addr       <= '0;
            beats_left <= '0;
            burst_left <= '0;
            err        <= 1'b0;
        end else begin
            if (cfg_fire) begin
                addr       <= {CONFIG_SRC[31:BEAT_LSB], {BEAT_LSB{1'b0}}};
                beats_left <= CONFIG_LEN[31:BEAT_LSB];
                err        <= 1'b0;
            end
            if (ar_fire) begin
                addr       <= addr + (32'(n_cur) << BEAT_LSB);
                beats_left <= beats_left - BL_W'(n_cur);
                burst_left <= n_cur;
            end
            if (beat_fire) begin
                burst_left <= burst_left - 5'd1;
                if ((ERR_EN != 0) && beat_err) err <= 1'b1;
            end
        end
    end

endmodule
